// File: rtl/serial_subtractor_if.sv
// Handshake and operand bundle for the bit-serial subtractor.
// Master issues operands and start; slave reports status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, difference,
    input  borrow_out, overflow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, difference,
    output borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first.
// One result bit per clock; outputs update only on completion.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);
  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_bout;
  logic             r_ovf;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br;
  logic             w_last;
  logic             w_accept;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

  assign w_ai     = r_a[r_cnt];
  assign w_bi     = r_b[r_cnt];
  assign w_d      = w_ai ^ w_bi ^ r_br;
  assign w_br     = (~w_ai & w_bi)
                  | (~(w_ai ^ w_bi) & r_br);
  assign w_last   = (r_cnt == CW'(MSB));
  assign w_accept = bus.start
                  && (r_state != S_SHIFT);
  assign w_ovf    = (r_a[MSB] != r_b[MSB])
                  && (w_d != r_a[MSB]);

  // Result including the bit being produced this cycle.
  always_comb begin
    w_res        = r_res;
    w_res[r_cnt] = w_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_diff  <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_br    <= bus.borrow_in;
      r_res   <= '0;
      r_cnt   <= '0;
      r_state <= S_SHIFT;
    end else begin
      unique case (1'b1)
        (r_state == S_SHIFT): begin
          r_res <= w_res;
          r_br  <= w_br;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff  <= w_res;
            r_bout  <= w_br;
            r_ovf   <= w_ovf;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = (r_state == S_SHIFT);
  assign bus.done       = (r_state == S_DONE);
  assign bus.difference = r_diff;
  assign bus.borrow_out = r_bout;
  assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor.
// Runs a 4-bit and an 8-bit instance against an arithmetic model.
module tb_serial_subtractor;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [33:0] held4;
  logic [33:0] held8;

  serial_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_subtractor_if #(.WIDTH(8)) bus8 ();

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [35:0] got,
                       logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  // {ovf, bout, diff} from signed/unsigned arithmetic
  function automatic logic [33:0] model(
    int w, longint ua, longint ub, longint bi);
    longint m, d, sa, sb, r;
    logic bout, ovf;
    m    = longint'(1) << w;
    d    = ((ua - ub - bi) % m + m) % m;
    bout = (ua < ub + bi);
    sa   = (ua >= m / 2) ? ua - m : ua;
    sb   = (ub >= m / 2) ? ub - m : ub;
    r    = sa - sb - bi;
    ovf  = (r < -(m / 2)) || (r > m / 2 - 1);
    return {ovf, bout, 32'(d)};
  endfunction

  // {busy, done, ovf, bout, diff}
  function automatic logic [35:0] obs(int w);
    if (w == 4)
      return {bus4.busy, bus4.done,
              bus4.overflow, bus4.borrow_out,
              28'd0, bus4.difference};
    return {bus8.busy, bus8.done,
            bus8.overflow, bus8.borrow_out,
            24'd0, bus8.difference};
  endfunction

  task automatic set_in(int w, logic st,
                        logic [31:0] a,
                        logic [31:0] b,
                        logic bi);
    if (w == 4) begin
      bus4.start     = st;
      bus4.a         = a[3:0];
      bus4.b         = b[3:0];
      bus4.borrow_in = bi;
    end else begin
      bus8.start     = st;
      bus8.a         = a[7:0];
      bus8.b         = b[7:0];
      bus8.borrow_in = bi;
    end
  endtask

  function automatic logic [33:0] held(int w);
    return (w == 4) ? held4 : held8;
  endfunction

  task automatic scramble(int w, logic st);
    set_in(w, st, $urandom, $urandom,
           1'($urandom));
  endtask

  // Caller is #1 after an edge, DUT not in SHIFT.
  task automatic op(int w, int a, int b,
                    int bi, bit inject);
    logic [33:0] exp;
    exp = model(w, a, b, bi);
    set_in(w, 1'b1, a, b, 1'(bi));
    @(posedge clk); #1;
    scramble(w, 1'b0);
    check("busy_k", obs(w),
          {2'b10, held(w)});
    for (int i = 1; i < w; i++) begin
      if (inject && i == 2) scramble(w, 1'b1);
      @(posedge clk); #1;
      if (inject && i == 2) scramble(w, 1'b0);
      check("busy_hold", obs(w),
            {2'b10, held(w)});
    end
    @(posedge clk); #1;
    check("result", obs(w), {2'b01, exp});
    if (w == 4) held4 = exp;
    else        held8 = exp;
  endtask

  task automatic idle(int w);
    @(posedge clk); #1;
    check("idle", obs(w), {2'b00, held(w)});
  endtask

  task automatic abort4();
    set_in(4, 1'b1, 9, 3, 1'b0);
    @(posedge clk); #1;
    scramble(4, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    held4 = '0;
    held8 = '0;
    #1;
    check("abort4", obs(4), 36'd0);
    check("abort8", obs(8), 36'd0);
    @(posedge clk); #1;
    check("abort_nodone", obs(4), 36'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_idle", obs(4), 36'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int w, a, b, bi;
    checks = 0;
    errors = 0;
    held4  = '0;
    held8  = '0;
    rst_n  = 1'b0;
    set_in(4, 1'b0, 0, 0, 1'b0);
    set_in(8, 1'b0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset4", obs(4), 36'd0);
    check("reset8", obs(8), 36'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(4, 9, 3, 0, 0);
    idle(4);
    op(4, 3, 9, 0, 0);
    idle(4);
    op(4, 5, 5, 1, 0);
    idle(4);
    op(4, 8, 1, 0, 0);
    op(4, 2, 1, 0, 0);
    idle(4);
    idle(4);
    op(4, 9, 3, 0, 1);
    idle(4);
    abort4();
    op(4, 12, 5, 1, 0);
    idle(4);
    op(8, 0, 1, 0, 0);
    idle(8);
    op(8, 255, 255, 1, 0);
    idle(8);

    for (int n = 0; n < 80; n++) begin
      w  = (n % 2 == 0) ? 4 : 8;
      a  = int'($urandom_range((1 << w) - 1));
      b  = int'($urandom_range((1 << w) - 1));
      bi = int'($urandom_range(1));
      op(w, a, b, bi, $urandom_range(3) == 0);
      if ($urandom_range(1) == 1) idle(w);
    end
    idle(4);
    idle(8);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end
endmodule
